piso_serializer: RTL
====================

# piso_serializer

Parallel-in/serial-out serializer with a valid/ready load handshake. It is the stage directly upstream of the SIPO deserializer. It accepts one WIDTH-bit word, then drives it out one bit per clock on `serial_out`, qualified by `shift_en`. Its `serial_out`/`shift_en` pair connects straight to the SIPO's `serial_in`/`shift_en`, so a loopback through both blocks reproduces the original word.

## Interface
- `WIDTH`, 8: data word width; legal range is 2 or more.
- `MSB_FIRST`, 1: 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load_valid` input 1: upstream presents a word on `parallel_in`.
- `load_ready` output 1: block can accept a word.
- `parallel_in` input WIDTH: word to serialize; sampled only on an accept.
- `serial_out` output 1: current serial bit (registered).
- `shift_en` output 1: `serial_out` holds a valid frame bit this cycle (registered).
- `busy` output 1: a frame is in progress (state is not IDLE).
- `done` output 1: one-cycle pulse after the last bit of a frame.

## Operation
- States are IDLE, SHIFT and PARITY. PARITY exists only when `PISO_PARITY_EN` is defined.
- An accept occurs on a rising edge where `load_valid && load_ready`.
- `load_ready` = (state == IDLE) && !rst. It is combinational from state.

**IDLE**
- `shift_en` = 0 and `serial_out` = 0.
- On an accept:
  - capture `parallel_in` into the shift register;
  - clear the bit counter;
  - go to SHIFT;
  - drive the first bit onto `serial_out` with `shift_en` = 1 from the same edge.

**SHIFT**
- Each edge advances the shift register by one position (left for MSB_FIRST=1, right for MSB_FIRST=0) and increments the counter.
- After WIDTH bits have been presented:
  - parity disabled: return to IDLE;
  - parity enabled: go to PARITY.

**PARITY**
- Present one bit, the XOR of the captured word (even parity), with `shift_en` = 1.
- Then return to IDLE.

**Completion and exceptions**
- `done` pulses for exactly one cycle, the first IDLE cycle after a completed frame.
- `load_valid` while not in IDLE is ignored. Upstream must hold the word until `load_ready` is high.
- `parallel_in` changes outside an accept edge have no effect on the frame in flight.
- Asserting `rst` mid-frame aborts the frame immediately:
  - all outputs go to their reset values;
  - `done` is not pulsed;
  - the next frame starts clean after `rst` drops.

**Bit counter**
- Width is $clog2(WIDTH+1).
- It never wraps within a frame; its terminal value is WIDTH-1.

**Reset values**
- Within `rst` assertion: state IDLE, `serial_out` 0, `shift_en` 0, `busy` 0, `done` 0, `load_ready` 0.
- `load_ready` rises combinationally when `rst` falls.

## Timing
- If the accept is on edge N, data bit k (k = 0..WIDTH-1 in transmit order) is valid in cycle N+1+k with `shift_en` = 1.
- With parity enabled, the parity bit is valid in cycle N+1+WIDTH.
- `done` is high in cycle N+1+WIDTH without parity, or N+2+WIDTH with parity. `load_ready` is high in that same cycle.
- Maximum throughput is one word per WIDTH+1 cycles, or WIDTH+2 with parity. There is exactly one idle gap cycle between back-to-back frames.
- `shift_en` is continuous across a frame, with no bubbles. The downstream SIPO sees exactly WIDTH shift pulses per frame (WIDTH+1 with parity).

## Configuration
- `PISO_PARITY_EN` defined:
  - PARITY state compiled in;
  - an even-parity bit is appended after the data bits;
  - frame length is WIDTH+1.
- `PISO_PARITY_EN` undefined:
  - no PARITY state and no parity logic;
  - frame length is exactly WIDTH.

## Structure
- `piso_pkg` holds the `piso_state_t` enum (IDLE, SHIFT, PARITY) and a `PISO_CNT_W(width)` helper function returning $clog2(width+1).
- One sub-module, `piso_bit_counter`, implements the counter:
  - inputs: clear, increment;
  - output: `last` flag when the count equals WIDTH-1.
- The top level holds the FSM, the shift register and the parity XOR.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `load_valid`=1. Required: all outputs 0, no accept. Release `rst`: `load_ready`=1 immediately.
- **MSB-first frame:** WIDTH=8, MSB_FIRST=1, accept 8'b10101100 at edge N. Required: `serial_out` = 1,0,1,0,1,1,0,0 in cycles N+1..N+8 with `shift_en`=1; `done`=1 only in cycle N+9. Loopback into the SIPO gives `parallel_out`=8'b10101100.
- **LSB-first frame:** MSB_FIRST=0, same word. Required: `serial_out` = 0,0,1,1,0,1,0,1.
- **Back-to-back:** hold `load_valid`=1 with 8'hA5 then 8'h3C. Required: second accept in cycle N+9 (the `done` cycle); its first bit in N+10; no `shift_en` bubble inside either frame.
- **Abort:** assert `rst` after 3 bits of 8'hFF. Required: `shift_en`/`serial_out` go to 0 asynchronously, no `done`; next frame 8'h81 serializes correctly.
- **Parity:** with `PISO_PARITY_EN`, send 8'b10101100. Required: parity bit 0 in cycle N+9, `done` in N+10. With 8'b10101101, parity bit 1.

Source files
------------

// File: rtl/piso_pkg.sv
// ----------------------------------------------------------------------------
// piso_pkg
// Shared types and helpers for the PISO serializer.
//   piso_state_t : FSM state encoding (PARITY present only with PISO_PARITY_EN)
//   PISO_CNT_W   : bit-counter width for a given word width, $clog2(width+1)
// Build option: PISO_PARITY_EN adds the PARITY state.
// ----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } piso_state_t;

    // Counter wide enough to hold 0..width
    function automatic int unsigned PISO_CNT_W(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// ----------------------------------------------------------------------------
// piso_bit_counter
// Counts data bits presented within a frame; saturates at WIDTH-1.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear_i   : force count to zero (takes priority)
//   incr_i    : advance count by one
//   last_o    : count equals WIDTH-1 (combinational from the count register)
// ----------------------------------------------------------------------------
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic incr_i,
    output logic last_o
);

    localparam int unsigned CNT_W = PISO_CNT_W(WIDTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins; increment stops at the terminal value
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (incr_i && !last_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
// Parallel-in/serial-out serializer with a valid/ready load handshake.
// Accepts a WIDTH-bit word and drives it out one bit per clock on serial_out,
// qualified by shift_en; feeds a SIPO deserializer directly.
// Build option: define PISO_PARITY_EN to append an even-parity bit.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load_valid   : upstream presents a word on parallel_in
//   load_ready   : block can accept a word (IDLE and not in reset)
//   parallel_in  : word to serialize, sampled only on an accept
//   serial_out   : current serial bit (registered)
//   shift_en     : serial_out carries a valid frame bit (registered)
//   busy         : a frame is in progress
//   done         : one-cycle pulse in the first IDLE cycle after a frame
// ----------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);

    piso_state_t      state_q;
    piso_state_t      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             serial_q;
    logic             serial_d;
    logic             shift_en_q;
    logic             shift_en_d;
    logic             done_q;
    logic             done_d;
`ifdef PISO_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    logic             accept;
    logic             cnt_clear;
    logic             cnt_incr;
    logic             cnt_last;

    // First transmitted bit of a freshly captured word
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Shift register after one advance; the new head is the next bit to send
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign load_ready = (state_q == IDLE) && !rst;
    assign accept     = load_valid && load_ready;

    piso_bit_counter #(
        .WIDTH   (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .incr_i  (cnt_incr),
        .last_o  (cnt_last)
    );

    // Next-state and next-output logic; serial_out/shift_en default to idle
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        serial_d   = 1'b0;
        shift_en_d = 1'b0;
        done_d     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_incr   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d    = parallel_in;
                    serial_d   = head_bit(parallel_in);
                    shift_en_d = 1'b1;
                    cnt_clear  = 1'b1;
                    state_d    = SHIFT;
`ifdef PISO_PARITY_EN
                    // Parity taken from the captured word, not the shifting copy
                    parity_d   = ^parallel_in;
`endif
                end
            end

            SHIFT: begin
                if (cnt_last) begin
`ifdef PISO_PARITY_EN
                    serial_d   = parity_q;
                    shift_en_d = 1'b1;
                    state_d    = PARITY;
`else
                    done_d     = 1'b1;
                    state_d    = IDLE;
`endif
                end else begin
                    shreg_d    = advance(shreg_q);
                    serial_d   = head_bit(advance(shreg_q));
                    shift_en_d = 1'b1;
                    cnt_incr   = 1'b1;
                end
            end

`ifdef PISO_PARITY_EN
            PARITY: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            serial_q   <= 1'b0;
            shift_en_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            serial_q   <= serial_d;
            shift_en_q <= shift_en_d;
            done_q     <= done_d;
`ifdef PISO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign serial_out = serial_q;
    assign shift_en   = shift_en_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule
